ghost_ucode_seq: RTL and testbench
==================================

// Module: ghost_ucode_seq
// PURPOSE
//  Microcode sequencer that drives the write/read side of the ghost register file.
//  Runs 32-bit MUL (low word), DIVU and REMU as shift-add / restoring-division loops.
//  All working state lives in ghost registers, which are accessed through the file's
//  rd/rs1/rs2/write port set. Sits beside the core datapath; the core issues one
//  start per operation and waits for done.
// PARAMETERS
//  G_A    4'd0  ghost index holding operand A (multiplicand / dividend)
//  G_B    4'd1  ghost index holding operand B (multiplier / divisor)
//  G_R    4'd2  ghost index: MUL accumulator / DIV remainder
//  G_Q    4'd3  ghost index: DIV quotient
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  start        in   1   request; sampled only when busy=0
//  op           in   2   00 MUL, 01 DIVU, 10 REMU, 11 illegal
//  operand_a    in   32  A, sampled with start
//  operand_b    in   32  B, sampled with start
//  busy         out  1   high from the cycle after start is accepted until done
//  done         out  1   one-cycle completion pulse
//  err          out  1   one-cycle pulse, coincident with done, for op=11
//  result       out  32  result; valid from done, held until the next accepted start
//  rd_g         out  4   ghost destination; also selects out_rd_g
//  rs1_g        out  4   ghost read select 1
//  rs2_g        out  4   ghost read select 2
//  write_g      out  1   ghost write enable
//  writeData_g  out  32  ghost write data
//  out_rd_g     in   32  ghost[rd_g], combinational
//  out_rs1_g    in   32  ghost[rs1_g], combinational
//  out_rs2_g    in   32  ghost[rs2_g], combinational
// BEHAVIOUR
//  Reset (async): state=IDLE; busy/done/err=0; result=0; iteration counter=0.
//   Ghost drive outputs are 0, so write_g=0 immediately.
//   rst must span >=1 clk edge, because the ghost file clears synchronously.
//  Ghost drive outputs are a combinational decode of state. At most one ghost write per cycle.
//  IDLE: start=1 latches op, A, B; clears result.
//   op=11: next edge pulses done=err=1, result=0, with no ghost writes.
//   Otherwise go to LD_A.
//  Load sequence, one state per cycle:
//   LD_A  (G_A <= A)
//   LD_B  (G_B <= B)
//   CL_R  (G_R <= 0)
//   CL_Q  (G_Q <= 0)
//   Then enter the loop with cnt=0.
//  MUL loop, 3 cycles per iteration:
//   M_ADD: rd=G_R, rs1=G_A, rs2=G_B; write out_rd_g + (out_rs2_g[0] ? out_rs1_g : 0), mod 2^32
//   M_SHA: rd=G_A; write out_rd_g<<1
//   M_SHB: rd=G_B; write out_rd_g>>1 (logical)
//  DIV loop (DIVU and REMU), 4 cycles per iteration:
//   D_SHR: rd=G_R, rs1=G_A; write {out_rd_g[30:0], out_rs1_g[31]}
//   D_SHA: rd=G_A; write out_rd_g<<1
//   D_SUB: rd=G_R, rs1=G_B; qbit <= (out_rd_g >= out_rs1_g), unsigned
//          write out_rd_g - out_rs1_g if qbit, else rewrite out_rd_g
//   D_Q:   rd=G_Q; write {out_rd_g[30:0], qbit}
//  Loop control: cnt increments on the last state of each iteration.
//   After the iteration with cnt=31, go to FIN.
//  FIN: rd_g = G_Q for DIVU, G_R for MUL/REMU; write_g=0.
//   Next edge: result <= out_rd_g, done=1, busy=0, state=IDLE.
//  Latency, counted in edges from the edge sampling start to done high:
//   MUL 101, DIVU/REMU 133, illegal 1.
//  Divide by zero needs no special case: the loop naturally yields Q=32'hFFFFFFFF, R=A.
//  start while busy: ignored, with no effect on latched operands.
//   start in the same cycle as done is ignored; it is accepted one cycle later.
//  Reset mid-operation: aborts immediately. No done pulse; ghost contents are don't-care.
// TESTING
//  MUL 7*6 -> done at edge 101, result=32'd42, err=0, busy high edges 1..100
//  MUL 32'hFFFFFFFF*2 -> result=32'hFFFFFFFE (wrap). MUL 0*x -> 0
//  DIVU 100/7 -> result=14 at edge 133; REMU 100/7 -> result=2
//  DIVU 32'h1234/0 -> 32'hFFFFFFFF; REMU 32'h1234/0 -> 32'h1234
//  Second start at edge 10 with different operands -> ignored, result unchanged. op=11 -> done=err=1 at edge 1, result=0
//  rst pulse at edge 50 of MUL -> busy=0 and write_g=0 immediately, no done; a fresh MUL 3*5 after it -> 15

Source files
------------

// File: rtl/ghost_ucode_seq.sv
// Microcode sequencer running 32-bit MUL / DIVU / REMU as shift-add and restoring-division
// loops, with every working value held in an external ghost register file.
module ghost_ucode_seq #(
  parameter logic [3:0] G_A = 4'd0,
  parameter logic [3:0] G_B = 4'd1,
  parameter logic [3:0] G_R = 4'd2,
  parameter logic [3:0] G_Q = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [3:0]  rd_g,
  output logic [3:0]  rs1_g,
  output logic [3:0]  rs2_g,
  output logic        write_g,
  output logic [31:0] writeData_g,
  input  logic [31:0] out_rd_g,
  input  logic [31:0] out_rs1_g,
  input  logic [31:0] out_rs2_g,
  output logic [3:0]  dbg_state
);

  // Handshake: start is taken only in IDLE while done is low; done (and err for op=11)
  // is a single-cycle pulse, and result stays valid until the next accepted start.
  typedef enum logic [3:0] {
    S_IDLE, S_ILL, S_LD_A, S_LD_B, S_CL_R, S_CL_Q,
    S_M_ADD, S_M_SHA, S_M_SHB,
    S_D_SHR, S_D_SHA, S_D_SUB, S_D_Q,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;
  logic        r_qbit;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_result;

  logic        w_ge;
  logic        w_last;

  assign w_ge   = (out_rd_g >= out_rs1_g);
  assign w_last = (r_cnt == 5'd31);

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;
  assign dbg_state = r_state;

  // Ghost port drive is a pure decode of state; the file returns reads combinationally.
  always_comb begin
    rd_g        = 4'd0;
    rs1_g       = 4'd0;
    rs2_g       = 4'd0;
    write_g     = 1'b0;
    writeData_g = 32'd0;
    case (r_state)
      S_LD_A:  begin rd_g = G_A; write_g = 1'b1; writeData_g = r_a; end
      S_LD_B:  begin rd_g = G_B; write_g = 1'b1; writeData_g = r_b; end
      S_CL_R:  begin rd_g = G_R; write_g = 1'b1; end
      S_CL_Q:  begin rd_g = G_Q; write_g = 1'b1; end
      S_M_ADD: begin
        rd_g        = G_R;
        rs1_g       = G_A;
        rs2_g       = G_B;
        write_g     = 1'b1;
        writeData_g = out_rd_g + (out_rs2_g[0] ? out_rs1_g : 32'd0);
      end
      S_M_SHA: begin rd_g = G_A; write_g = 1'b1; writeData_g = out_rd_g << 1; end
      S_M_SHB: begin rd_g = G_B; write_g = 1'b1; writeData_g = out_rd_g >> 1; end
      S_D_SHR: begin
        rd_g        = G_R;
        rs1_g       = G_A;
        write_g     = 1'b1;
        writeData_g = {out_rd_g[30:0], out_rs1_g[31]};
      end
      S_D_SHA: begin rd_g = G_A; write_g = 1'b1; writeData_g = out_rd_g << 1; end
      S_D_SUB: begin
        rd_g        = G_R;
        rs1_g       = G_B;
        write_g     = 1'b1;
        writeData_g = w_ge ? (out_rd_g - out_rs1_g) : out_rd_g;
      end
      S_D_Q:   begin rd_g = G_Q; write_g = 1'b1; writeData_g = {out_rd_g[30:0], r_qbit}; end
      S_FIN:   rd_g = (r_op == OP_DIVU) ? G_Q : G_R;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_cnt    <= 5'd0;
      r_qbit   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_op     <= op;
            r_a      <= operand_a;
            r_b      <= operand_b;
            r_result <= 32'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
            r_state  <= (op == OP_ILL) ? S_ILL : S_LD_A;
          end
        end
        S_ILL: begin
          r_done  <= 1'b1;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_LD_A:  r_state <= S_LD_B;
        S_LD_B:  r_state <= S_CL_R;
        S_CL_R:  r_state <= S_CL_Q;
        S_CL_Q:  r_state <= (r_op == OP_MUL) ? S_M_ADD : S_D_SHR;
        S_M_ADD: r_state <= S_M_SHA;
        S_M_SHA: r_state <= S_M_SHB;
        S_M_SHB: begin
          r_cnt   <= r_cnt + 5'd1;
          r_state <= w_last ? S_FIN : S_M_ADD;
        end
        S_D_SHR: r_state <= S_D_SHA;
        S_D_SHA: r_state <= S_D_SUB;
        S_D_SUB: begin
          r_qbit  <= w_ge;
          r_state <= S_D_Q;
        end
        S_D_Q: begin
          r_cnt   <= r_cnt + 5'd1;
          r_state <= w_last ? S_FIN : S_D_SHR;
        end
        S_FIN: begin
          r_result <= out_rd_g;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_ucode_seq.sv
// Directed bench for ghost_ucode_seq with a behavioural ghost register file attached.
module tb_ghost_ucode_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy, done, err, write_g;
  logic [31:0] result, writeData_g;
  logic [3:0]  rd_g, rs1_g, rs2_g, dbg_state;
  logic [31:0] out_rd_g, out_rs1_g, out_rs2_g;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  ghost_ucode_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .rd_g(rd_g), .rs1_g(rs1_g), .rs2_g(rs2_g),
    .write_g(write_g), .writeData_g(writeData_g),
    .out_rd_g(out_rd_g), .out_rs1_g(out_rs1_g), .out_rs2_g(out_rs2_g),
    .dbg_state(dbg_state)
  );

  // Ghost register file: synchronous write and clear, combinational reads.
  logic [31:0] ghost [16];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ghost[i] <= 32'd0;
    end else if (write_g) begin
      ghost[rd_g] <= writeData_g;
    end
  end
  assign out_rd_g  = ghost[rd_g];
  assign out_rs1_g = ghost[rs1_g];
  assign out_rs2_g = ghost[rs2_g];

  always @(posedge clk) if (write_g) wr_cnt <= wr_cnt + 1;

  // Issues one operation and reports the edge count from accept to done.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int lat, output logic [31:0] res, output logic er,
                        output logic busy_ok, output int writes);
    int w0;
    @(negedge clk);
    if (done) @(negedge clk);
    start = 1'b1; op = op_i; operand_a = a_i; operand_b = b_i;
    w0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy;
    lat = 0; res = 32'hDEADBEEF; er = 1'bx;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; res = result; er = err; busy_ok = busy_ok & !busy;
        break;
      end
      busy_ok = busy_ok & busy;
    end
    writes = wr_cnt - w0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, err, write_g} !== 4'b0000 || result !== 32'd0 || rd_g !== 4'd0 || dbg_state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b err=%b wr=%b result=%h rd=%0d st=%0d, required all zero",
               busy, done, err, write_g, result, rd_g, dbg_state);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat, wr; logic [31:0] res; logic er, bok;
    logic [31:0] va [3] = '{32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] vb [3] = '{32'd6, 32'd2, 32'h89ABCDEF};
    logic [31:0] ve [3] = '{32'd42, 32'hFFFFFFFE, 32'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(2'b00, va[i], vb[i], lat, res, er, bok, wr);
      n_checks++;
      if (lat !== 101) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d, required 101", i, lat); end
      n_checks++;
      if (res !== ve[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h, required %h", i, res, ve[i]); end
      n_checks++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL mul_err[%0d]: got %b, required 0", i, er); end
      n_checks++;
      if (bok !== 1'b1) begin n_fail++; $display("FAIL mul_busy[%0d]: busy window wrong", i); end
      n_checks++;
      if (wr !== 100) begin n_fail++; $display("FAIL mul_writes[%0d]: got %0d, required 100", i, wr); end
    end
  endtask

  task automatic test_div;
    int lat, wr; logic [31:0] res; logic er, bok;
    logic [1:0]  vo [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] va [4] = '{32'd100, 32'd100, 32'h1234, 32'h1234};
    logic [31:0] vb [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] ve [4] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      run_op(vo[i], va[i], vb[i], lat, res, er, bok, wr);
      n_checks++;
      if (lat !== 133) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d, required 133", i, lat); end
      n_checks++;
      if (res !== ve[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h, required %h", i, res, ve[i]); end
      n_checks++;
      if (er !== 1'b0 || bok !== 1'b1) begin n_fail++; $display("FAIL div_flags[%0d]: err=%b busy_ok=%b, required 0/1", i, er, bok); end
      n_checks++;
      if (wr !== 132) begin n_fail++; $display("FAIL div_writes[%0d]: got %0d, required 132", i, wr); end
    end
  endtask

  task automatic test_illegal;
    int lat, wr; logic [31:0] res; logic er, bok;
    run_op(2'b11, 32'd5, 32'd6, lat, res, er, bok, wr);
    n_checks++;
    if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL illegal_done: lat=%0d err=%b, required 1/1", lat, er); end
    n_checks++;
    if (res !== 32'd0) begin n_fail++; $display("FAIL illegal_result: got %h, required 0", res); end
    n_checks++;
    if (wr !== 0) begin n_fail++; $display("FAIL illegal_writes: got %0d, required 0", wr); end
  endtask

  task automatic test_ignore_start;
    int lat = 0;
    @(negedge clk);
    if (done) @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == 10) begin start = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd3; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 101) begin n_fail++; $display("FAIL ignore_latency: got %0d, required 101", lat); end
    n_checks++;
    if (result !== 32'd42) begin n_fail++; $display("FAIL ignore_result: got %h, required 0000002a", result); end
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    start = 1'b1; op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || result !== 32'd42) begin
      n_fail++; $display("FAIL b2b_ignored: busy=%b result=%h, required 0/0000002a", busy, result);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || result !== 32'd0) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b result=%h, required 1/00000000", busy, result);
    end
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 133 || result !== 32'd14) begin
      n_fail++; $display("FAIL b2b_divu: lat=%0d result=%h, required 133/0000000e", lat, result);
    end
  endtask

  task automatic test_reset_abort;
    int lat, wr; logic [31:0] res; logic er, bok;
    logic seen_done = 1'b0;
    @(negedge clk);
    if (done) @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (write_g !== 1'b1) begin n_fail++; $display("FAIL abort_pre: write_g=%b, required 1", write_g); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || write_g !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_immediate: busy=%b write_g=%b done=%b, required 0/0/0", busy, write_g, done);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (120) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: done observed, required none"); end
    run_op(2'b00, 32'd3, 32'd5, lat, res, er, bok, wr);
    n_checks++;
    if (lat !== 101 || res !== 32'd15) begin
      n_fail++; $display("FAIL abort_fresh_mul: lat=%0d result=%h, required 101/0000000f", lat, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_illegal();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
